// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for the two-port memory arbiter
package mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int unsigned PROT_WORDS_DEFAULT = 64;

  // True when the word address of a byte address falls inside the program region.
  function automatic logic in_prot(input logic [31:0] addr, input int unsigned words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    // On contention the port that did not win last time gets the slot.
    if (req == 2'b11) begin
      gnt = ~last_grant;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares a single-ported memory between CPU and auxiliary master
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned PROT_WORDS = PROT_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   gnt_q, gnt_d;
  logic   is_read_q, is_read_d;
  logic   err_q, err_d;

  logic        arb_gnt;
  logic        arb_any;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wmask;
  logic        sel_blocked;

  rr_arb2 u_rr_arb2 (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .any        (arb_any)
  );

  assign sel_addr  = (arb_gnt == PORT_AUX) ? p1_addr  : p0_addr;
  assign sel_wdata = (arb_gnt == PORT_AUX) ? p1_wdata : p0_wdata;
  assign sel_wmask = (arb_gnt == PORT_AUX) ? p1_wmask : p0_wmask;

  // Only auxiliary-port writes into the program region are suppressed.
  assign sel_blocked = (arb_gnt == PORT_AUX) && (sel_wmask != 4'b0000) &&
                       in_prot(sel_addr, PROT_WORDS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_AUX;
      gnt_q        <= PORT_CPU;
      is_read_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      is_read_q    <= is_read_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    is_read_d    = is_read_q;
    err_d        = err_q;
    mem_addr     = 32'h0;
    mem_rstrb    = 1'b0;
    mem_wdata    = 32'h0;
    mem_wmask    = 4'b0000;
    p0_ack       = 1'b0;
    p0_rdata     = 32'h0;
    p1_ack       = 1'b0;
    p1_rdata     = 32'h0;
    p1_err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Gating with resetn keeps the memory pins quiet while reset is held.
        if (arb_any && resetn) begin
          mem_addr  = sel_addr;
          mem_wdata = sel_wdata;
          if (sel_wmask == 4'b0000) begin
            mem_rstrb = 1'b1;
          end else if (!sel_blocked) begin
            mem_wmask = sel_wmask;
          end
          gnt_d        = arb_gnt;
          is_read_d    = (sel_wmask == 4'b0000);
          err_d        = sel_blocked;
          last_grant_d = arb_gnt;
          state_d      = ST_ACK;
        end
      end

      ST_ACK: begin
        if (gnt_q == PORT_CPU) begin
          p0_ack   = 1'b1;
          p0_rdata = is_read_q ? mem_rdata : 32'h0;
        end else begin
          p1_ack   = 1'b1;
          p1_rdata = is_read_q ? mem_rdata : 32'h0;
          p1_err   = err_q;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        p0_req, p1_req;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_wmask, p1_wmask;
  logic        p0_ack, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.PROT_WORDS(64)) dut (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-ported memory: 256 words, byte mask, registered read.
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i == 100) ? 32'h04030201 : (32'hA5000000 | 32'(i));
      end
      mem_loaded <= 1'b1;
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask);
    if (p == 0) begin
      p0_req = req; p0_addr = addr; p0_wdata = wdata; p0_wmask = wmask;
    end else begin
      p1_req = req; p1_addr = addr; p1_wdata = wdata; p1_wmask = wmask;
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? p0_ack : p1_ack;
  endfunction

  function automatic logic [31:0] get_rd(input int p);
    return (p == 0) ? p0_rdata : p1_rdata;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        exp_rstrb;
    logic [3:0]  exp_mwmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  // Single transaction from an idle arbiter: issue cycle then ack cycle.
  task automatic run_vec(input vec_t v);
    drive(v.port, 1'b1, v.addr, v.wdata, v.wmask);
    @(negedge clk);
    chk("vec_rstrb", 32'(mem_rstrb), 32'(v.exp_rstrb));
    chk("vec_mem_wmask", 32'(mem_wmask), 32'(v.exp_mwmask));
    chk("vec_mem_addr", mem_addr, v.addr);
    chk("vec_mem_wdata", mem_wdata, v.wdata);
    step();
    @(negedge clk);
    chk("vec_own_ack", 32'(get_ack(v.port)), 32'd1);
    chk("vec_other_ack", 32'(get_ack(1 - v.port)), 32'd0);
    chk("vec_rdata", get_rd(v.port), v.exp_rdata);
    chk("vec_other_rdata", get_rd(1 - v.port), 32'h0);
    chk("vec_p1_err", 32'(p1_err), 32'(v.exp_err));
    step();
    drive(v.port, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  logic [31:0] shadow [256];
  logic [31:0] snap [256];
  logic        pend [2];
  int          waitc [2];
  logic        done [2];
  int          diffs;

  initial begin
    vecs[0]  = '{0, 32'd400, 32'h0,        4'h0, 1'b1, 4'h0, 32'h04030201, 1'b0};
    vecs[1]  = '{0, 32'd400, 32'h000000AA, 4'h1, 1'b0, 4'h1, 32'h0,        1'b0};
    vecs[2]  = '{0, 32'd400, 32'h0,        4'h0, 1'b1, 4'h0, 32'h040302AA, 1'b0};
    vecs[3]  = '{1, 32'd8,   32'hFFFFFFFF, 4'hF, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[4]  = '{1, 32'd8,   32'h0,        4'h0, 1'b1, 4'h0, 32'hA5000002, 1'b0};
    vecs[5]  = '{1, 32'd400, 32'h12345678, 4'hF, 1'b0, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1, 32'd400, 32'h0,        4'h0, 1'b1, 4'h0, 32'h12345678, 1'b0};
    vecs[7]  = '{0, 32'd8,   32'hCAFE0000, 4'hC, 1'b0, 4'hC, 32'h0,        1'b0};
    vecs[8]  = '{1, 32'd10,  32'h0,        4'h0, 1'b1, 4'h0, 32'hCAFE0002, 1'b0};
    vecs[9]  = '{1, 32'd252, 32'hDEADBEEF, 4'hF, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[10] = '{1, 32'd256, 32'h64646464, 4'hF, 1'b0, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1, 32'd256, 32'h0,        4'h0, 1'b1, 4'h0, 32'h64646464, 1'b0};
    vecs[12] = '{0, 32'd252, 32'h0,        4'h0, 1'b1, 4'h0, 32'hA500003F, 1'b0};
    vecs[13] = '{1, 32'd255, 32'h0000BBBB, 4'h3, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[14] = '{0, 32'd252, 32'h11111111, 4'hF, 1'b0, 4'hF, 32'h0,        1'b0};
    vecs[15] = '{1, 32'd252, 32'h0,        4'h0, 1'b1, 4'h0, 32'h11111111, 1'b0};

    // Reset with both masters already requesting.
    resetn = 1'b0;
    drive(0, 1'b1, 32'd400, 32'h0, 4'h0);
    drive(1, 1'b1, 32'd404, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_rstrb", 32'(mem_rstrb), 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
    chk("rst_p1_err", 32'(p1_err), 32'd0);
    step();
    resetn = 1'b1;

    // Contention held continuously: acks land on even cycles, p0 first, then alternate.
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("cont_first_addr", mem_addr, 32'd400);
        chk("cont_first_rstrb", 32'(mem_rstrb), 32'd1);
      end
      if (c == 3) chk("cont_second_addr", mem_addr, 32'd404);
      chk("cont_p0_ack", 32'(p0_ack), 32'((c % 4) == 2));
      chk("cont_p1_ack", 32'(p1_ack), 32'((c % 4) == 0));
      if (c == 2) chk("cont_p0_rdata", p0_rdata, 32'h04030201);
      if (c == 4) chk("cont_p1_rdata", p1_rdata, 32'hA5000065);
      step();
    end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Reset asserted during the ack cycle of a p0 read.
    drive(0, 1'b1, 32'd404, 32'h0, 4'h0);
    step();
    resetn = 1'b0;
    drive(1, 1'b1, 32'd400, 32'h0, 4'h0);
    @(negedge clk);
    chk("midrst_p0_ack", 32'(p0_ack), 32'd0);
    chk("midrst_p0_rdata", p0_rdata, 32'h0);
    chk("midrst_mem", {31'd0, mem_rstrb} | mem_addr | 32'(mem_wmask), 32'h0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_grant_addr", mem_addr, 32'd404);
    step();
    @(negedge clk);
    chk("postrst_p0_ack", 32'(p0_ack), 32'd1);
    chk("postrst_p0_rdata", p0_rdata, 32'hA5000065);
    step();
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("postrst_p1_addr", mem_addr, 32'd400);
    step();
    @(negedge clk);
    chk("postrst_p1_ack", 32'(p1_ack), 32'd1);
    chk("postrst_p1_rdata", p1_rdata, 32'h12345678);
    step();
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Idle hygiene.
    for (int i = 0; i < 256; i++) snap[i] = mem[i];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_mem_ctrl", {27'd0, mem_rstrb, mem_wmask}, 32'd0);
      chk("idle_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    end
    step();
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
    chk("idle_mem_unchanged", 32'(diffs), 32'd0);

    // Randomised traffic against a transaction-level shadow image.
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; waitc[p] = 0; done[p] = 1'b0;
    end
    for (int cyc = 0; cyc < 620; cyc++) begin
      @(negedge clk);
      chk("rand_one_ack", 32'(p0_ack & p1_ack), 32'd0);
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a, wd, exp_rd;
        logic [3:0]  wm;
        logic        prot;
        a  = (p == 0) ? p0_addr : p1_addr;
        wd = (p == 0) ? p0_wdata : p1_wdata;
        wm = (p == 0) ? p0_wmask : p1_wmask;
        if (pend[p]) waitc[p]++;
        if (get_ack(p)) begin
          if (!pend[p]) begin
            chk("rand_spurious_ack", 32'd1, 32'd0);
          end else begin
            prot   = (p == 1) && (wm != 4'h0) && (a[31:2] < 30'd64);
            exp_rd = (wm == 4'h0) ? shadow[a[9:2]] : 32'h0;
            chk("rand_rdata", get_rd(p), exp_rd);
            if (p == 1) chk("rand_p1_err", 32'(p1_err), 32'(prot));
            chk("rand_latency_le4", 32'(waitc[p] <= 4), 32'd1);
            if (wm != 4'h0 && !prot) begin
              for (int b = 0; b < 4; b++)
                if (wm[b]) shadow[a[9:2]][8*b +: 8] = wd[8*b +: 8];
            end
            done[p] = 1'b1;
          end
        end else begin
          chk("rand_rdata_idle", get_rd(p), 32'h0);
        end
      end
      if (!p1_ack) chk("rand_p1_err_idle", 32'(p1_err), 32'd0);
      step();
      for (int p = 0; p < 2; p++) begin
        if (done[p]) begin
          done[p] = 1'b0;
          pend[p] = 1'b0;
          drive(p, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        if (!pend[p] && cyc < 600 && $urandom_range(0, 1) == 1) begin
          logic [31:0] na;
          logic [3:0]  nm;
          na = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
          nm = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          drive(p, 1'b1, na, $urandom, nm);
          pend[p] = 1'b1;
          waitc[p] = 0;
        end
      end
    end
    chk("rand_drained", {30'd0, pend[1], pend[0]}, 32'd0);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) diffs++;
    chk("rand_mem_image", 32'(diffs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
